// File: rtl/led7scan_decoder.sv
// Snoops a multiplexed active-low 7-segment bus and recovers one BCD digit per scan slot.
// Latency: a slot is captured on the STABLE_CYCLES-th identical sample; the frame appears one edge after the last capture.
// No backpressure: o_w_valid is a one-cycle strobe and the outputs hold until the next frame. Optional LED7DEC_ERR_EN adds o_w_frame_err.
module led7scan_decoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  i_w_clk,
    input  logic                  i_w_reset,
    input  logic [6:0]            i_w_seg,
    input  logic [DIGITS-1:0]     i_w_an,
    output logic [4*DIGITS-1:0]   o_w_digits,
    output logic [DIGITS-1:0]     o_w_invalid,
    output logic                  o_w_valid
`ifdef LED7DEC_ERR_EN
   ,output logic                  o_w_frame_err
`endif
);

    localparam int SW = DIGITS + 7;
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 2);

    typedef enum logic {S_WAIT, S_HELD} state_t;

    // Returns {invalid, nibble} for an active-low gfedcba pattern.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b1000000: r = {1'b0, 4'h0};
            7'b1111001: r = {1'b0, 4'h1};
            7'b0100100: r = {1'b0, 4'h2};
            7'b0110000: r = {1'b0, 4'h3};
            7'b0011001: r = {1'b0, 4'h4};
            7'b0010010: r = {1'b0, 4'h5};
            7'b0000010: r = {1'b0, 4'h6};
            7'b1111000: r = {1'b0, 4'h7};
            7'b0000000: r = {1'b0, 4'h8};
            7'b0011000: r = {1'b0, 4'h9};
            7'b1111111: r = {1'b0, 4'hF};
            default:    r = {1'b1, 4'hE};
        endcase
        return r;
    endfunction

    logic [SW-1:0]          sample_q;
    logic [CW-1:0]          cnt_q,        cnt_d;
    state_t                 state_q,      state_d;
    logic [4*DIGITS-1:0]    shadow_dig_q, shadow_dig_d;
    logic [DIGITS-1:0]      shadow_inv_q, shadow_inv_d;
    logic [DIGITS-1:0]      mask_q,       mask_d;
    logic                   done_q,       done_d;
    logic [4*DIGITS-1:0]    digits_q,     digits_d;
    logic [DIGITS-1:0]      invalid_q,    invalid_d;
    logic                   valid_q;
`ifdef LED7DEC_ERR_EN
    logic                   dup_q,        dup_d;
    logic                   frame_err_q;
`endif

    logic [SW-1:0]          sample_now;
    logic                   same;
    logic [DIGITS-1:0]      an_low;
    logic                   onehot;
    logic                   capture;
    logic [4:0]             dec;
    logic [DIGITS-1:0]      mask_base;

    // Stability tracking, slot selection and the capture decision for this edge.
    always_comb begin
        sample_now = {i_w_an, i_w_seg};
        same       = (sample_now == sample_q);
        an_low     = ~i_w_an;
        onehot     = (an_low != '0) && ((an_low & (an_low - 1'b1)) == '0);
        capture    = (state_q == S_WAIT) && same && (cnt_q == CNT_LAST) && onehot;
        dec        = decode_seg(i_w_seg);
        // The completion edge empties the mask before any capture on that edge lands.
        mask_base  = done_q ? '0 : mask_q;
    end

    // Next-state for counter, FSM, shadow frame and published outputs.
    always_comb begin
        cnt_d        = '0;
        state_d      = state_q;
        shadow_dig_d = shadow_dig_q;
        shadow_inv_d = shadow_inv_q;
        mask_d       = mask_base;
        done_d       = 1'b0;
        digits_d     = digits_q;
        invalid_d    = invalid_q;

        if (same) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        if (!same) begin
            state_d = S_WAIT;
        end else if (capture) begin
            state_d = S_HELD;
        end

        if (capture) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (an_low[i]) begin
                    shadow_dig_d[4*i +: 4] = dec[3:0];
                    shadow_inv_d[i]        = dec[4];
                end
            end
            mask_d = mask_base | an_low;
            done_d = ((mask_base | an_low) == {DIGITS{1'b1}});
        end

        if (done_q) begin
            digits_d  = shadow_dig_q;
            invalid_d = shadow_inv_q;
        end
    end

`ifdef LED7DEC_ERR_EN
    // A capture into a slot that is already filled in the current frame is a duplicate.
    always_comb begin
        dup_d = capture && ((mask_base & an_low) != '0);
    end
`endif

    // State registers with synchronous reset; reset drops any partial frame.
    always_ff @(posedge i_w_clk) begin
        if (i_w_reset) begin
            sample_q     <= '1;
            cnt_q        <= '0;
            state_q      <= S_WAIT;
            shadow_dig_q <= '0;
            shadow_inv_q <= '0;
            mask_q       <= '0;
            done_q       <= 1'b0;
            digits_q     <= {DIGITS{4'hF}};
            invalid_q    <= '0;
            valid_q      <= 1'b0;
`ifdef LED7DEC_ERR_EN
            dup_q        <= 1'b0;
            frame_err_q  <= 1'b0;
`endif
        end else begin
            sample_q     <= sample_now;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_inv_q <= shadow_inv_d;
            mask_q       <= mask_d;
            done_q       <= done_d;
            digits_q     <= digits_d;
            invalid_q    <= invalid_d;
            valid_q      <= done_q;
`ifdef LED7DEC_ERR_EN
            dup_q        <= dup_d;
            frame_err_q  <= dup_q;
`endif
        end
    end

    assign o_w_digits  = digits_q;
    assign o_w_invalid = invalid_q;
    assign o_w_valid   = valid_q;
`ifdef LED7DEC_ERR_EN
    assign o_w_frame_err = frame_err_q;
`endif

endmodule

// File: tb/tb_led7scan_decoder.sv
// Bench for led7scan_decoder: directed scenarios plus random scan traffic against a run-length reference model.
// Every cycle the DUT outputs are compared with the model one time unit after the rising edge.
// Stimulus is applied freely; the DUT has no backpressure.
module tb_led7scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        i_w_reset = 1'b1;
    logic [6:0]  i_w_seg = 7'h7F;
    logic [3:0]  i_w_an = 4'hF;
    logic [15:0] o_w_digits;
    logic [3:0]  o_w_invalid;
    logic        o_w_valid;
`ifdef LED7DEC_ERR_EN
    logic        o_w_frame_err;
`endif

    always #5 clk = ~clk;

    led7scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
        .i_w_clk     (clk),
        .i_w_reset   (i_w_reset),
        .i_w_seg     (i_w_seg),
        .i_w_an      (i_w_an),
        .o_w_digits  (o_w_digits),
        .o_w_invalid (o_w_invalid),
        .o_w_valid   (o_w_valid)
`ifdef LED7DEC_ERR_EN
       ,.o_w_frame_err (o_w_frame_err)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Segment patterns for digits 0..9, active-low gfedcba.
    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

    // Reference model: run length of identical samples, per-slot shadow, fill set.
    logic [10:0] prev_m;
    int          run_m;
    logic [3:0]  sh_dig [4];
    logic        sh_inv [4];
    bit          filled [4];
    bit          done_m, dup_m;
    logic [15:0] dig_m;
    logic [3:0]  inv_m;
    bit          valid_m, err_m;
    int          valid_cnt, err_cnt;

    task automatic model_step(input bit rst, input logic [3:0] an, input logic [6:0] seg);
        int idx, zeros;
        bit all;
        logic [3:0] nib;
        logic bad;
        if (rst) begin
            prev_m = '1; run_m = 1; done_m = 0; dup_m = 0;
            for (int i = 0; i < 4; i++) begin filled[i] = 0; sh_dig[i] = 4'h0; sh_inv[i] = 0; end
            dig_m = 16'hFFFF; inv_m = 4'h0; valid_m = 0; err_m = 0;
            return;
        end
        if ({an, seg} == prev_m) run_m++; else run_m = 1;
        prev_m = {an, seg};
        valid_m = done_m;
        err_m = dup_m;
        dup_m = 0;
        if (done_m) begin
            for (int i = 0; i < 4; i++) begin
                dig_m[4*i +: 4] = sh_dig[i];
                inv_m[i] = sh_inv[i];
                filled[i] = 0;
            end
        end
        done_m = 0;
        idx = 0; zeros = 0;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) begin zeros++; idx = i; end
        if (run_m == STABLE && zeros == 1) begin
            nib = 4'hE; bad = 1'b1;
            if (seg == 7'h7F) begin nib = 4'hF; bad = 1'b0; end
            for (int d = 0; d < 10; d++) if (seg == seg_tab[d]) begin nib = 4'(d); bad = 1'b0; end
            if (filled[idx]) dup_m = 1;
            filled[idx] = 1;
            sh_dig[idx] = nib;
            sh_inv[idx] = bad;
            all = 1;
            for (int i = 0; i < 4; i++) all = all & filled[i];
            if (all) done_m = 1;
        end
    endtask

    task automatic tick(input bit rst, input logic [3:0] an, input logic [6:0] seg);
        i_w_reset = rst;
        i_w_an    = an;
        i_w_seg   = seg;
        @(posedge clk);
        model_step(rst, an, seg);
        #1;
        check_eq("valid", {31'b0, o_w_valid}, {31'b0, valid_m});
        check_eq("digits", {16'b0, o_w_digits}, {16'b0, dig_m});
        check_eq("invalid", {28'b0, o_w_invalid}, {28'b0, inv_m});
        if (o_w_valid) valid_cnt++;
`ifdef LED7DEC_ERR_EN
        check_eq("frame_err", {31'b0, o_w_frame_err}, {31'b0, err_m});
        if (o_w_frame_err) err_cnt++;
`endif
    endtask

    task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
        repeat (n) tick(1'b0, an, seg);
    endtask

    initial begin
        logic [3:0] an_r;
        logic [6:0] seg_r;
        valid_cnt = 0;
        err_cnt = 0;

        // Reset state
        tick(1'b1, 4'hF, 7'h7F);
        tick(1'b1, 4'hF, 7'h7F);
        check_eq("reset_digits", {16'b0, o_w_digits}, 32'hFFFF);
        check_eq("reset_invalid", {28'b0, o_w_invalid}, 32'h0);
        check_eq("reset_valid", {31'b0, o_w_valid}, 32'h0);

        // Full scan
        valid_cnt = 0;
        hold(4'b1110, 7'b0100100, 8);
        hold(4'b1101, 7'b1000000, 8);
        hold(4'b1011, 7'b0100100, 8);
        hold(4'b0111, 7'b0010010, 8);
        check_eq("scan_pulses", valid_cnt, 1);
        check_eq("scan_digits", {16'b0, o_w_digits}, 32'h5202);
        check_eq("scan_invalid", {28'b0, o_w_invalid}, 32'h0);

        // Glitch on slot 0 is not captured
        valid_cnt = 0;
        hold(4'b1110, 7'b1111001, 3);
        hold(4'b1111, 7'h7F, 4);
        hold(4'b1101, 7'b1111001, 8);
        hold(4'b1011, 7'b0110000, 8);
        hold(4'b0111, 7'b0011001, 8);
        check_eq("glitch_no_frame", valid_cnt, 0);
        hold(4'b1110, 7'b0000000, 8);
        check_eq("glitch_then_frame", valid_cnt, 1);
        check_eq("glitch_digits", {16'b0, o_w_digits}, 32'h4318);

        // Undecodable and blank patterns
        valid_cnt = 0;
        hold(4'b1110, 7'b0110000, 8);
        hold(4'b1101, 7'b1111111, 8);
        hold(4'b1011, 7'b1111110, 8);
        hold(4'b0111, 7'b0011000, 8);
        check_eq("bad_pulses", valid_cnt, 1);
        check_eq("bad_digits", {16'b0, o_w_digits}, 32'h9EF3);
        check_eq("bad_invalid", {28'b0, o_w_invalid}, 32'h4);

        // Illegal anodes never capture
        valid_cnt = 0;
        hold(4'b1100, 7'b0000000, 20);
        hold(4'b1111, 7'b1000000, 20);
        check_eq("illegal_no_frame", valid_cnt, 0);
        hold(4'b1110, 7'b1111000, 8);
        hold(4'b1101, 7'b0000010, 8);
        hold(4'b1011, 7'b0010010, 8);
        check_eq("illegal_mask_kept", valid_cnt, 0);
        hold(4'b0111, 7'b0011001, 8);
        check_eq("illegal_then_frame", valid_cnt, 1);
        check_eq("illegal_digits", {16'b0, o_w_digits}, 32'h4567);

        // Reset mid-frame discards slots 0 and 1
        valid_cnt = 0;
        hold(4'b1110, 7'b0011000, 8);
        hold(4'b1101, 7'b0000000, 8);
        tick(1'b1, 4'b1101, 7'b0000000);
        check_eq("midrst_digits", {16'b0, o_w_digits}, 32'hFFFF);
        hold(4'b1011, 7'b1000000, 8);
        hold(4'b0111, 7'b1111000, 8);
        check_eq("midrst_no_frame", valid_cnt, 0);
        hold(4'b1110, 7'b0100100, 8);
        hold(4'b1101, 7'b1111001, 8);
        check_eq("midrst_pulses", valid_cnt, 1);
        check_eq("midrst_frame", {16'b0, o_w_digits}, 32'h7012);

`ifdef LED7DEC_ERR_EN
        // Duplicate capture on slot 0
        valid_cnt = 0;
        err_cnt = 0;
        hold(4'b1110, 7'b0110000, 8);
        hold(4'b1110, 7'b1111000, 8);
        hold(4'b1101, 7'b1000000, 8);
        hold(4'b1011, 7'b1000000, 8);
        hold(4'b0111, 7'b1000000, 8);
        check_eq("dup_err_pulses", err_cnt, 1);
        check_eq("dup_frame_pulses", valid_cnt, 1);
        check_eq("dup_digits", {16'b0, o_w_digits}, 32'h0007);
`endif

        // Random scan traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(39, 0) == 0) begin
                tick(1'b1, 4'hF, 7'h7F);
            end
            if ($urandom_range(9, 0) < 7) begin
                an_r = 4'hF;
                an_r[$urandom_range(3, 0)] = 1'b0;
            end else begin
                an_r = 4'($urandom_range(15, 0));
            end
            case ($urandom_range(9, 0))
                0:       seg_r = 7'h7F;
                1, 2:    seg_r = 7'($urandom_range(127, 0));
                default: seg_r = seg_tab[$urandom_range(9, 0)];
            endcase
            hold(an_r, seg_r, $urandom_range(8, 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
